// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage.
// result = {remainder, quotient}; holds the pipeline via stallreq until ready.
// Optional early termination for |dividend| < |divisor| is built when the
// macro DIV_EARLY_OUT_EN is defined; the default build omits the comparator.
module div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     opdata1,
  input  logic [WIDTH-1:0]     opdata2,
  input  logic                 annul,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 stallreq
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend magnitude, shifts into quotient
  logic [WIDTH-1:0]   dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0]   rem_q, rem_d;   // partial remainder between steps
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic               neg1_q, neg1_d;
  logic               neg2_q, neg2_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               op1_neg_c, op2_neg_c, divzero_c, early_c;
  logic [WIDTH-1:0]   mag1_c, mag2_c;
  logic [WIDTH:0]     trial_c, diff_c;
  logic               qbit_c, last_c;
  logic [WIDTH-1:0]   rem_nxt_c, quo_nxt_c, rem_fix_c, quo_fix_c;

  // Operand magnitudes straight from the inputs (only consumed in IDLE)
  always_comb begin
    op1_neg_c = signed_op & opdata1[WIDTH-1];
    op2_neg_c = signed_op & opdata2[WIDTH-1];
    mag1_c    = op1_neg_c ? (~opdata1 + WIDTH'(1)) : opdata1;
    mag2_c    = op2_neg_c ? (~opdata2 + WIDTH'(1)) : opdata2;
    divzero_c = (opdata2 == '0);
  end

`ifdef DIV_EARLY_OUT_EN
  // Quotient is zero whenever the dividend magnitude is below the divisor's
  assign early_c = ~divzero_c & (mag1_c < mag2_c);
`else
  assign early_c = 1'b0;
`endif

  // One restoring-subtract step plus the sign fix-up applied on the last step
  always_comb begin
    trial_c   = {rem_q, dvd_q[WIDTH-1]};
    diff_c    = trial_c - {1'b0, dvs_q};
    qbit_c    = ~diff_c[WIDTH];
    rem_nxt_c = qbit_c ? diff_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
    quo_nxt_c = {dvd_q[WIDTH-2:0], qbit_c};
    quo_fix_c = (sgn_q & (neg1_q ^ neg2_q)) ? (~quo_nxt_c + WIDTH'(1)) : quo_nxt_c;
    rem_fix_c = (sgn_q & neg1_q) ? (~rem_nxt_c + WIDTH'(1)) : rem_nxt_c;
    last_c    = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  // Next-state logic; annul wins over everything else
  always_comb begin
    state_d = state_q;
    if (annul) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (divzero_c)    state_d = ST_BYZERO;
            else if (early_c) state_d = ST_END;
            else              state_d = ST_ON;
          end
        end
        ST_BYZERO: state_d = ST_END;
        ST_ON:     if (last_c) state_d = ST_END;
        ST_END:    if (!start) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and registered-output updates per state
  always_comb begin
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    ready_d  = ready_q;
    result_d = result_q;
    if (annul) begin
      ready_d  = 1'b0;
      result_d = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            sgn_d  = signed_op;
            neg1_d = op1_neg_c;
            neg2_d = op2_neg_c;
            dvs_d  = mag2_c;
            rem_d  = '0;
            cnt_d  = '0;
            // Divide-by-zero keeps the raw dividend for the remainder slot
            dvd_d  = divzero_c ? opdata1 : mag1_c;
            if (!divzero_c && early_c) begin
              ready_d  = 1'b1;
              result_d = {opdata1, {WIDTH{1'b0}}};
            end
          end
        end
        ST_BYZERO: begin
          ready_d  = 1'b1;
          result_d = {dvd_q, {WIDTH{1'b1}}};
        end
        ST_ON: begin
          rem_d = rem_nxt_c;
          dvd_d = quo_nxt_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_c) begin
            ready_d  = 1'b1;
            result_d = {rem_fix_c, quo_fix_c};
          end
        end
        ST_END: begin
          if (!start) begin
            ready_d  = 1'b0;
            result_d = '0;
          end
        end
        default: begin
          ready_d  = 1'b0;
          result_d = '0;
        end
      endcase
    end
  end

  assign result   = result_q;
  assign ready    = ready_q;
  assign stallreq = start & ~ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (WIDTH=32) against an arithmetic model.
// Honors DIV_EARLY_OUT_EN the same way the design does.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int          checks = 0;
  int          errors = 0;
  logic        exp_ready;
  logic [63:0] exp_result;
  bit          chk_en;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .annul     (annul),
    .result    (result),
    .ready     (ready),
    .stallreq  (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Reference: plain integer division; latency from the documented timing
  task automatic model(input bit s, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] r);
    longint sa, sb, q, rm, ma, mb;
    if (b == 32'd0) begin
      lat = 2;
      r   = {a, 32'hFFFF_FFFF};
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      q   = sa / sb;
      rm  = sa % sb;
      r   = {rm[31:0], q[31:0]};
      ma  = (sa < 0) ? -sa : sa;
      mb  = (sb < 0) ? -sb : sb;
      lat = 33;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) lat = 1;
`else
      if (ma < mb) lat = 33;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every output on every cycle against the expectation
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 64'(ready), 64'(exp_ready));
      chk("result", result, exp_ready ? exp_result : 64'd0);
      chk("stallreq", 64'(stallreq), 64'(start & ~exp_ready));
    end
  end

  // Full operation; start held 'hold' cycles past ready, then released
  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat;
    logic [63:0] r;
    model(s, a, b, lat, r);
    exp_result = r;
    start = 1'b1; signed_op = s; opdata1 = a; opdata2 = b; exp_ready = 1'b0;
    for (int c = 0; c <= lat + hold; c++) begin
      exp_ready = (c >= lat);
      tick();
      // Operand churn outside IDLE must be ignored
      opdata1 = $urandom; opdata2 = $urandom; signed_op = 1'($urandom_range(0, 1));
    end
    start = 1'b0; exp_ready = 1'b1;
    tick();
    exp_ready = 1'b0;
    tick();
    tick();
  endtask

  // Operation cancelled by annul in cycle 'at'
  task automatic run_annul(input bit s, input logic [31:0] a, input logic [31:0] b, input int at);
    int lat;
    logic [63:0] r;
    model(s, a, b, lat, r);
    exp_result = r;
    start = 1'b1; signed_op = s; opdata1 = a; opdata2 = b; exp_ready = 1'b0;
    for (int c = 0; c <= at; c++) begin
      exp_ready = (c >= lat);
      if (c == at) annul = 1'b1;
      tick();
    end
    annul = 1'b0; start = 1'b0; exp_ready = 1'b0;
    tick();
    tick();
  endtask

  // Asynchronous reset in cycle 'at', then restart with start still held
  task automatic run_reset(input bit s, input logic [31:0] a, input logic [31:0] b, input int at);
    int lat;
    logic [63:0] r;
    model(s, a, b, lat, r);
    exp_result = r;
    start = 1'b1; signed_op = s; opdata1 = a; opdata2 = b; exp_ready = 1'b0;
    for (int c = 0; c < at; c++) begin
      exp_ready = (c >= lat);
      tick();
    end
    exp_ready = (at >= lat);
    #2;
    rst = 1'b0;
    exp_ready = 1'b0;
    #1;
    chk("async_rst_ready", 64'(ready), 64'd0);
    chk("async_rst_result", result, 64'd0);
    tick();
    rst = 1'b1;
    run_op(s, a, b, 0);
  endtask

  initial begin
    int          lat;
    logic [63:0] r;
    bit          s;
    logic [31:0] a, b;
    int          kind;

    rst = 1'b1; start = 1'b0; signed_op = 1'b0; opdata1 = '0; opdata2 = '0; annul = 1'b0;
    exp_ready = 1'b0; exp_result = '0; chk_en = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Hand-computed pins on the model
    model(1'b0, 32'd100, 32'd7, lat, r);
    chk("pin_100_7", r, {32'd2, 32'd14});
    chk("pin_100_7_lat", 64'(lat), 64'd33);
    model(1'b1, 32'hFFFF_FFF9, 32'd2, lat, r);
    chk("pin_m7_2", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, r);
    chk("pin_mostneg", r, {32'h0000_0000, 32'h8000_0000});
    model(1'b0, 32'd5, 32'd0, lat, r);
    chk("pin_byzero", r, {32'd5, 32'hFFFF_FFFF});
    chk("pin_byzero_lat", 64'(lat), 64'd2);
    model(1'b0, 32'd3, 32'd10, lat, r);
    chk("pin_early", r, {32'd3, 32'd0});
`ifdef DIV_EARLY_OUT_EN
    chk("pin_early_lat", 64'(lat), 64'd1);
`else
    chk("pin_early_lat", 64'(lat), 64'd33);
`endif

    // Directed scenarios
    run_op(1'b0, 32'd100, 32'd7, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 32'd5, 32'd0, 2);
    run_annul(1'b0, 32'd100, 32'd7, 10);
    run_op(1'b0, 32'd9, 32'd3, 0);
    run_reset(1'b0, 32'd100, 32'd7, 15);
    run_op(1'b0, 32'd3, 32'd10, 2);
    run_op(1'b1, 32'd3, 32'hFFFF_FFF6, 1);
    run_op(1'b1, 32'h8000_0000, 32'd3, 0);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: a = $urandom_range(0, 50);
        3: begin a = 32'h8000_0000; if ($urandom_range(0, 1) == 1) b = 32'hFFFF_FFFF; end
        4: b = {16'd0, b[15:0]};
        default: ;
      endcase
      model(s, a, b, lat, r);
      kind = int'($urandom_range(0, 5));
      if (kind == 0)      run_annul(s, a, b, int'($urandom_range(0, lat + 1)));
      else if (kind == 1) run_reset(s, a, b, int'($urandom_range(1, lat + 1)));
      else                run_op(s, a, b, int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
